// File: rtl/alarm_trigger_pkg.sv
// ============================================================================
// alarm_trigger_pkg : shared state encoding and time field widths
// Rev 1.0
// ============================================================================
`default_nettype none

package alarm_trigger_pkg;

  localparam int c_HOUR_W  = 5;
  localparam int c_MIN_W   = 6;
  localparam int c_SEC_W   = 6;
  localparam int c_STATE_W = 2;

  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_IDLE    = 2'd0;
  localparam state_t c_ST_RINGING = 2'd1;
  localparam state_t c_ST_SNOOZE  = 2'd2;

  // A terminal count of 1 still needs a one-bit counter
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_trigger_match.sv
// ============================================================================
// alarm_match : time compare plus rising-edge detect, one trigger per match
// Rev 1.0
// ============================================================================
`default_nettype none

module alarm_match
  import alarm_trigger_pkg::*;
(
  input  logic                clock,
  input  logic                reset_min,
  input  logic                i_alarm_en,
  input  logic [c_HOUR_W-1:0] i_cur_hour,
  input  logic [c_MIN_W-1:0]  i_cur_min,
  input  logic [c_SEC_W-1:0]  i_cur_sec,
  input  logic [c_HOUR_W-1:0] i_alarm_hour,
  input  logic [c_MIN_W-1:0]  i_alarm_min,
  output logic                o_trigger
);

  logic w_match;
  logic r_match_d;

  assign w_match = i_alarm_en
                 & (i_cur_hour == i_alarm_hour)
                 & (i_cur_min  == i_alarm_min)
                 & (i_cur_sec  == '0);

  // Resets high so a match already present at reset release is not an edge
  always_ff @(posedge clock or posedge reset_min) begin
    if (reset_min) r_match_d <= 1'b1;
    else           r_match_d <= w_match;
  end

  assign o_trigger = w_match & ~r_match_d;

endmodule

`default_nettype wire

// File: rtl/alarm_trigger.sv
// ============================================================================
// alarm_trigger : alarm clock ring / snooze controller with registered buzzer
// Rev 1.0
// ============================================================================
`default_nettype none

module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                clock,
  input  logic                reset_min,
  input  logic                tick_1hz,
  input  logic [c_HOUR_W-1:0] cur_hour,
  input  logic [c_MIN_W-1:0]  cur_min,
  input  logic [c_SEC_W-1:0]  cur_sec,
  input  logic [c_HOUR_W-1:0] alarm_hour,
  input  logic [c_MIN_W-1:0]  alarm_min,
  input  logic                alarm_en,
  input  logic                stop,
  input  logic                snooze,
  output logic                buzzer,
  output logic                ringing,
  output logic                snoozing,
  output logic [1:0]          snooze_left
);

  localparam int c_RING_W = cnt_width(RING_SEC);
  localparam int c_SNZ_W  = cnt_width(SNOOZE_SEC);

  localparam logic [c_RING_W-1:0] c_RING_LAST = c_RING_W'(RING_SEC - 1);
  localparam logic [c_RING_W-1:0] c_RING_ONE  = c_RING_W'(1);
  localparam logic [c_SNZ_W-1:0]  c_SNZ_LAST  = c_SNZ_W'(SNOOZE_SEC - 1);
  localparam logic [c_SNZ_W-1:0]  c_SNZ_ONE   = c_SNZ_W'(1);
  localparam logic [1:0]          c_SNZ_MAX   = 2'(MAX_SNOOZE);

  logic                w_trigger;
  state_t              r_state,       w_state_nxt;
  logic [c_RING_W-1:0] r_ring_cnt,    w_ring_cnt_nxt;
  logic [c_SNZ_W-1:0]  r_snz_cnt,     w_snz_cnt_nxt;
  logic [1:0]          r_snooze_left, w_snooze_left_nxt;
  logic                r_buzzer,      w_buzzer_nxt;

  alarm_match u_match (
    .clock        (clock),
    .reset_min    (reset_min),
    .i_alarm_en   (alarm_en),
    .i_cur_hour   (cur_hour),
    .i_cur_min    (cur_min),
    .i_cur_sec    (cur_sec),
    .i_alarm_hour (alarm_hour),
    .i_alarm_min  (alarm_min),
    .o_trigger    (w_trigger)
  );

  always_ff @(posedge clock or posedge reset_min) begin
    if (reset_min) begin
      r_state       <= c_ST_IDLE;
      r_ring_cnt    <= '0;
      r_snz_cnt     <= '0;
      r_snooze_left <= c_SNZ_MAX;
      r_buzzer      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ring_cnt    <= w_ring_cnt_nxt;
      r_snz_cnt     <= w_snz_cnt_nxt;
      r_snooze_left <= w_snooze_left_nxt;
      r_buzzer      <= w_buzzer_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_ring_cnt_nxt    = r_ring_cnt;
    w_snz_cnt_nxt     = r_snz_cnt;
    w_snooze_left_nxt = r_snooze_left;
    w_buzzer_nxt      = r_buzzer;

    case (r_state)
      c_ST_IDLE: begin
        if (w_trigger) begin
          w_state_nxt    = c_ST_RINGING;
          w_ring_cnt_nxt = '0;
          w_buzzer_nxt   = 1'b1;
        end
      end

      c_ST_RINGING: begin
        if (stop || !alarm_en) begin
          w_state_nxt = c_ST_IDLE;
        end else if (snooze && (r_snooze_left != 2'd0)) begin
          w_state_nxt       = c_ST_SNOOZE;
          w_snooze_left_nxt = r_snooze_left - 2'd1;
          w_snz_cnt_nxt     = '0;
          w_buzzer_nxt      = 1'b0;
        end else if (tick_1hz) begin
          if (r_ring_cnt == c_RING_LAST) begin
            w_state_nxt = c_ST_IDLE;
          end else begin
            w_ring_cnt_nxt = r_ring_cnt + c_RING_ONE;
            w_buzzer_nxt   = ~r_buzzer;
          end
        end
      end

      c_ST_SNOOZE: begin
        if (stop || !alarm_en) begin
          w_state_nxt = c_ST_IDLE;
        end else if (tick_1hz) begin
          if (r_snz_cnt == c_SNZ_LAST) begin
            w_state_nxt    = c_ST_RINGING;
            w_ring_cnt_nxt = '0;
            w_buzzer_nxt   = 1'b1;
          end else begin
            w_snz_cnt_nxt = r_snz_cnt + c_SNZ_ONE;
          end
        end
      end

      default: w_state_nxt = c_ST_IDLE;
    endcase

    // Every path back to IDLE restores the idle-entry values
    if (w_state_nxt == c_ST_IDLE) begin
      w_ring_cnt_nxt    = '0;
      w_snz_cnt_nxt     = '0;
      w_snooze_left_nxt = c_SNZ_MAX;
      w_buzzer_nxt      = 1'b0;
    end
  end

  always_comb begin
    ringing     = (r_state == c_ST_RINGING);
    snoozing    = (r_state == c_ST_SNOOZE);
    buzzer      = r_buzzer;
    snooze_left = r_snooze_left;
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger.sv
// ============================================================================
// tb_alarm_trigger : directed self-checking bench for alarm_trigger
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alarm_trigger;

  logic       clock = 1'b0;
  logic       reset_min = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic [4:0] alarm_hour = 5'd7;
  logic [5:0] alarm_min = 6'd30;
  logic       alarm_en = 1'b1;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_left;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_trigger dut (
    .clock       (clock),
    .reset_min   (reset_min),
    .tick_1hz    (tick_1hz),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .alarm_hour  (alarm_hour),
    .alarm_min   (alarm_min),
    .alarm_en    (alarm_en),
    .stop        (stop),
    .snooze      (snooze),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_left (snooze_left)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    step();
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Brings the clock up to 07:30:00; the DUT should ring on that edge
  task automatic do_trigger();
    set_time(7, 29, 59);
    step();
    step();
    set_time(7, 30, 0);
    step();
    set_time(7, 30, 1);
  endtask

  task automatic test_reset();
    reset_min = 1'b1;
    step();
    step();
    n_checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs ring=%b snz=%b buz=%b exp 0/0/0", ringing, snoozing, buzzer);
    end
    n_checks++;
    if (snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_snooze_left got=%0d exp=3", snooze_left);
    end
    reset_min = 1'b0;
    step();
  endtask

  task automatic test_ring_timeout();
    do_trigger();
    n_checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_start ring=%b buz=%b exp 1/1", ringing, buzzer);
    end
    pulse_tick();
    n_checks++;
    if (buzzer !== 1'b0 || ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_tick1 buz=%b ring=%b exp 0/1", buzzer, ringing);
    end
    pulse_tick();
    n_checks++;
    if (buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_tick2 buz=%b exp 1", buzzer);
    end
    for (int i = 2; i < 59; i++) pulse_tick();
    n_checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_tick59 ring=%b buz=%b exp 1/0", ringing, buzzer);
    end
    pulse_tick();
    n_checks++;
    if (ringing !== 1'b0 || buzzer !== 1'b0 || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL ring_timeout ring=%b buz=%b left=%0d exp 0/0/3", ringing, buzzer, snooze_left);
    end
  endtask

  task automatic test_snooze();
    do_trigger();
    pulse_snooze();
    n_checks++;
    if (snoozing !== 1'b1 || ringing !== 1'b0 || buzzer !== 1'b0 || snooze_left !== 2'd2) begin
      n_fail++;
      $display("FAIL snooze_enter snz=%b ring=%b buz=%b left=%0d exp 1/0/0/2",
               snoozing, ringing, buzzer, snooze_left);
    end
    pulse_snooze();
    n_checks++;
    if (snoozing !== 1'b1 || snooze_left !== 2'd2) begin
      n_fail++;
      $display("FAIL snooze_in_snooze snz=%b left=%0d exp 1/2", snoozing, snooze_left);
    end
    for (int i = 0; i < 299; i++) pulse_tick();
    n_checks++;
    if (snoozing !== 1'b1 || ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL snooze_tick299 snz=%b ring=%b exp 1/0", snoozing, ringing);
    end
    pulse_tick();
    n_checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b1 || snoozing !== 1'b0 || snooze_left !== 2'd2) begin
      n_fail++;
      $display("FAIL snooze_expire ring=%b buz=%b snz=%b left=%0d exp 1/1/0/2",
               ringing, buzzer, snoozing, snooze_left);
    end
    pulse_stop();
    n_checks++;
    if (ringing !== 1'b0 || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL snooze_stop ring=%b left=%0d exp 0/3", ringing, snooze_left);
    end
  endtask

  task automatic test_max_snooze();
    do_trigger();
    for (int k = 0; k < 3; k++) begin
      pulse_snooze();
      for (int i = 0; i < 300; i++) pulse_tick();
    end
    n_checks++;
    if (ringing !== 1'b1 || snooze_left !== 2'd0) begin
      n_fail++;
      $display("FAIL max_snooze_used ring=%b left=%0d exp 1/0", ringing, snooze_left);
    end
    pulse_snooze();
    n_checks++;
    if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_left !== 2'd0) begin
      n_fail++;
      $display("FAIL fourth_snooze ring=%b snz=%b left=%0d exp 1/0/0", ringing, snoozing, snooze_left);
    end
    pulse_stop();
    n_checks++;
    if (ringing !== 1'b0 || snooze_left !== 2'd3 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL max_snooze_stop ring=%b left=%0d buz=%b exp 0/3/0", ringing, snooze_left, buzzer);
    end
  endtask

  task automatic test_stop_and_snooze();
    do_trigger();
    pulse_snooze();
    for (int i = 0; i < 300; i++) pulse_tick();
    n_checks++;
    if (ringing !== 1'b1 || snooze_left !== 2'd2) begin
      n_fail++;
      $display("FAIL stop_snz_pre ring=%b left=%0d exp 1/2", ringing, snooze_left);
    end
    stop   = 1'b1;
    snooze = 1'b1;
    step();
    stop   = 1'b0;
    snooze = 1'b0;
    n_checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0 || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL stop_wins ring=%b snz=%b left=%0d exp 0/0/3", ringing, snoozing, snooze_left);
    end
  endtask

  task automatic test_no_retrigger();
    int bad;
    do_trigger();
    set_time(7, 30, 0);
    pulse_stop();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ringing !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_retrigger ringing_cycles=%0d exp 0", bad);
    end
    pulse_snooze();
    pulse_stop();
    n_checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0 || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL idle_buttons ring=%b snz=%b left=%0d exp 0/0/3", ringing, snoozing, snooze_left);
    end
    alarm_en = 1'b0;
    set_time(7, 29, 59);
    step();
    set_time(7, 30, 0);
    step();
    step();
    n_checks++;
    if (ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_match ring=%b exp 0", ringing);
    end
    alarm_en = 1'b1;
  endtask

  task automatic test_disable_while_ringing();
    do_trigger();
    pulse_tick();
    alarm_en = 1'b0;
    step();
    alarm_en = 1'b1;
    n_checks++;
    if (ringing !== 1'b0 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_ring ring=%b buz=%b exp 0/0", ringing, buzzer);
    end
  endtask

  task automatic test_reset_mid_ring();
    do_trigger();
    set_time(7, 30, 0);
    for (int i = 0; i < 10; i++) pulse_tick();
    n_checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_ring ring=%b buz=%b exp 1/1", ringing, buzzer);
    end
    #2;
    reset_min = 1'b1;
    #1;
    n_checks++;
    if (ringing !== 1'b0 || buzzer !== 1'b0 || snoozing !== 1'b0 || snooze_left !== 2'd3) begin
      n_fail++;
      $display("FAIL async_reset ring=%b buz=%b snz=%b left=%0d exp 0/0/0/3",
               ringing, buzzer, snoozing, snooze_left);
    end
    step();
    reset_min = 1'b0;
    step();
    step();
    step();
    n_checks++;
    if (ringing !== 1'b0 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL match_at_release ring=%b buz=%b exp 0/0", ringing, buzzer);
    end
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_max_snooze();
    test_stop_and_snooze();
    test_no_retrigger();
    test_disable_while_ringing();
    test_reset_mid_ring();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
